// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset sequencer: filters a synchronised PLL lock flag, then releases
// the TMDS, pixel and camera resets in that order; lock loss or restart drops all at once.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int LOCK_FILT = 1024,
  parameter int STAGE_DLY = 256,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_pll_locked,
  input  logic             i_force_rst,
  output logic             o_rst_tmds_n,
  output logic             o_rst_pix_n,
  output logic             o_rst_cam_n,
  output logic             o_ready,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_loss_cnt
);

  localparam int MAX_CNT = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
  localparam int CW      = $clog2(MAX_CNT);
  localparam logic [CW-1:0]    FILT_LAST  = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0]    STAGE_LAST = CW'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX   = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_ls;
  logic [CW-1:0]    r_cnt;
  logic             r_stage;
  logic             r_rst_tmds_n;
  logic             r_rst_pix_n;
  logic             r_rst_cam_n;
  logic             r_ready;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             w_lost;

  // Only a drop after the filter has passed counts as a loss.
  assign w_lost = !r_ls && ((r_state == RELEASE) || (r_state == RUN));

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_s1         <= 1'b0;
      r_ls         <= 1'b0;
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_stage      <= 1'b0;
      r_rst_tmds_n <= 1'b0;
      r_rst_pix_n  <= 1'b0;
      r_rst_cam_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_loss_cnt   <= '0;
    end else begin
      r_s1 <= i_pll_locked;
      r_ls <= r_s1;
      if (i_force_rst || w_lost) begin
        r_state      <= WAIT_LOCK;
        r_rst_tmds_n <= 1'b0;
        r_rst_pix_n  <= 1'b0;
        r_rst_cam_n  <= 1'b0;
        r_ready      <= 1'b0;
        // A restart masks a coincident loss, so only count pure losses.
        if (!i_force_rst && (r_loss_cnt != LOSS_MAX))
          r_loss_cnt <= r_loss_cnt + 1'b1;
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            if (r_ls) begin
              r_state <= FILTER;
              r_cnt   <= '0;
            end
          end
          FILTER: begin
            if (!r_ls) begin
              r_state <= WAIT_LOCK;
            end else if (r_cnt == FILT_LAST) begin
              r_state      <= RELEASE;
              r_cnt        <= '0;
              r_stage      <= 1'b0;
              r_rst_tmds_n <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (r_cnt == STAGE_LAST) begin
              if (!r_stage) begin
                r_rst_pix_n <= 1'b1;
                r_stage     <= 1'b1;
                r_cnt       <= '0;
              end else begin
                r_rst_cam_n <= 1'b1;
                r_ready     <= 1'b1;
                r_state     <= RUN;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          RUN: begin
            r_state <= RUN;
          end
          default: begin
            r_state <= WAIT_LOCK;
          end
        endcase
      end
    end
  end

  assign o_rst_tmds_n = r_rst_tmds_n;
  assign o_rst_pix_n  = r_rst_pix_n;
  assign o_rst_cam_n  = r_rst_cam_n;
  assign o_ready      = r_ready;
  assign o_state      = r_state;
  assign o_loss_cnt   = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output bundles are queued against
// absolute cycle numbers when stimulus is driven, and compared on the following negedges.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int LF = 16;
  localparam int SD = 8;
  localparam int CW = 8;

  logic          clk;
  logic          resetn;
  logic          pll_locked;
  logic          force_rst;
  logic          rst_tmds_n;
  logic          rst_pix_n;
  logic          rst_cam_n;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] loss_cnt;

  pll_reset_sequencer #(.LOCK_FILT(LF), .STAGE_DLY(SD), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_pll_locked (pll_locked),
    .i_force_rst  (force_rst),
    .o_rst_tmds_n (rst_tmds_n),
    .o_rst_pix_n  (rst_pix_n),
    .o_rst_cam_n  (rst_cam_n),
    .o_ready      (ready),
    .o_state      (state),
    .o_loss_cnt   (loss_cnt)
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [13:0] bundle(input logic t, input logic p, input logic c,
                                         input logic r, input logic [1:0] st, input int loss);
    return {t, p, c, r, st, loss[7:0]};
  endfunction

  task automatic push(input string tag, input int at, input logic [13:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = at;
    e.val = v;
    sb.push_back(e);
  endtask

  // Ordered release where FILTER is entered at edge e (relative to base); entries beyond upto are skipped.
  task automatic exp_release(input string tag, input int base, input int e, input int upto, input int loss);
    int k[8] = '{e-1, e, e+15, e+16, e+23, e+24, e+31, e+32};
    logic [13:0] v[8];
    v[0] = bundle(0, 0, 0, 0, 2'd0, loss);
    v[1] = bundle(0, 0, 0, 0, 2'd1, loss);
    v[2] = bundle(0, 0, 0, 0, 2'd1, loss);
    v[3] = bundle(1, 0, 0, 0, 2'd2, loss);
    v[4] = bundle(1, 0, 0, 0, 2'd2, loss);
    v[5] = bundle(1, 1, 0, 0, 2'd2, loss);
    v[6] = bundle(1, 1, 0, 0, 2'd2, loss);
    v[7] = bundle(1, 1, 1, 1, 2'd3, loss);
    for (int i = 0; i < 8; i++)
      if (k[i] <= upto) push($sformatf("%s_e%0d", tag, k[i]), base + k[i], v[i]);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [13:0] obs;
    obs = {rst_tmds_n, rst_pix_n, rst_cam_n, ready, state, loss_cnt};
    if (cyc > 0)
      chk("order", {30'd0, rst_cam_n & ~rst_pix_n, rst_pix_n & ~rst_tmds_n}, 32'd0);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_late"}, cyc, e.cyc);
      else begin
        chk(e.tag, {18'd0, obs}, {18'd0, e.val});
        $display("cyc %0d %s obs=0x%0h exp=0x%0h", cyc, e.tag, obs, e.val);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int loss;
    resetn = 1'b0;
    pll_locked = 1'b0;
    force_rst = 1'b0;
    push("reset", 1, bundle(0, 0, 0, 0, 2'd0, 0));
    push("reset_hold", 4, bundle(0, 0, 0, 0, 2'd0, 0));
    repeat (4) @(negedge clk);
    resetn = 1'b1;

    // Clean start.
    base = cyc;
    pll_locked = 1'b1;
    exp_release("clean", base, 3, 99, 0);
    repeat (36) @(negedge clk);

    // Lock loss while running, then relock.
    base = cyc;
    pll_locked = 1'b0;
    push("loss_e2", base + 2, bundle(1, 1, 1, 1, 2'd3, 0));
    push("loss_e3", base + 3, bundle(0, 0, 0, 0, 2'd0, 1));
    repeat (6) @(negedge clk);
    base = cyc;
    pll_locked = 1'b1;
    exp_release("relock", base, 3, 99, 1);
    repeat (36) @(negedge clk);

    // force_rst on the same edge the FSM first sees ls low.
    base = cyc;
    pll_locked = 1'b0;
    push("frc_e2", base + 2, bundle(1, 1, 1, 1, 2'd3, 1));
    push("frc_e3", base + 3, bundle(0, 0, 0, 0, 2'd0, 1));
    push("frc_e5", base + 5, bundle(0, 0, 0, 0, 2'd0, 1));
    repeat (2) @(negedge clk);
    force_rst = 1'b1;
    @(negedge clk);
    force_rst = 1'b0;
    repeat (3) @(negedge clk);

    // Glitch during filtering at filter cycle 10.
    base = cyc;
    pll_locked = 1'b1;
    push("glitch_e3", base + 3, bundle(0, 0, 0, 0, 2'd1, 1));
    push("glitch_e12", base + 12, bundle(0, 0, 0, 0, 2'd1, 1));
    push("glitch_e13", base + 13, bundle(0, 0, 0, 0, 2'd0, 1));
    repeat (10) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    exp_release("glitch_re", cyc, 3, 99, 1);
    repeat (36) @(negedge clk);

    // Restart from RUN with lock held, then resetn while stage 1 of release.
    base = cyc;
    force_rst = 1'b1;
    exp_release("restart", base, 2, 29, 1);
    push("mid_e29", base + 29, bundle(1, 1, 0, 0, 2'd2, 1));
    push("mid_rst", base + 30, bundle(0, 0, 0, 0, 2'd0, 0));
    @(negedge clk);
    force_rst = 1'b0;
    repeat (28) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_release("after_rst", cyc, 3, 99, 0);
    repeat (36) @(negedge clk);

    // Saturation: 300 lock losses from RUN.
    loss = 0;
    for (int i = 0; i < 300; i++) begin
      base = cyc;
      pll_locked = 1'b0;
      push("sat_e2", base + 2, bundle(1, 1, 1, 1, 2'd3, loss));
      loss = (loss < 255) ? loss + 1 : 255;
      push("sat_e3", base + 3, bundle(0, 0, 0, 0, 2'd0, loss));
      repeat (5) @(negedge clk);
      pll_locked = 1'b1;
      exp_release("sat_re", cyc, 3, 99, loss);
      repeat (36) @(negedge clk);
    end
    chk("sat_final", {24'd0, loss_cnt}, 32'd255);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
